// File: rtl/bnn_pkg.sv
// Shared types and default geometry for the BNN feature feeder and its helpers.
// Width helpers track the default classifier configuration.
package bnn_pkg;

    localparam int unsigned DEF_FEAT_CNT      = 19;
    localparam int unsigned DEF_FEAT_BITS     = 4;
    localparam int unsigned DEF_CLASS_CNT     = 3;
    localparam int unsigned DEF_SETTLE_CYCLES = 45;

    localparam int unsigned IDX_W  = $clog2(DEF_FEAT_CNT);
    localparam int unsigned CNT_W  = $clog2(DEF_SETTLE_CYCLES);
    localparam int unsigned PRED_W = $clog2(DEF_CLASS_CNT);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/bnn_feat_shift.sv
// Right-shifting feature assembler: new element enters at the top, oldest ends at the LSBs.
// One-cycle update on shift_en; holds otherwise.
module bnn_feat_shift #(
    parameter int unsigned CNT  = 19,
    parameter int unsigned BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en,
    input  logic [BITS-1:0]       din,
    output logic [CNT*BITS-1:0]   vec
);

    logic [CNT*BITS-1:0] vec_q;
    logic [CNT*BITS-1:0] vec_d;

    always_comb begin
        vec_d = vec_q;
        if (shift_en) begin
            vec_d = {din, vec_q[CNT*BITS-1:BITS]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q <= '0;
        end else begin
            vec_q <= vec_d;
        end
    end

    assign vec = vec_q;

endmodule

// File: rtl/bnn_feature_feeder.sv
// Streams one feature per handshake into a packed vector, runs the classifier for a fixed
// window with its reset released, then presents the captured prediction on a valid/ready port.
module bnn_feature_feeder
    import bnn_pkg::*;
#(
    parameter int unsigned FEAT_CNT      = DEF_FEAT_CNT,
    parameter int unsigned FEAT_BITS     = DEF_FEAT_BITS,
    parameter int unsigned CLASS_CNT     = DEF_CLASS_CNT,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [FEAT_BITS-1:0]          in_feat,
    output logic [FEAT_CNT*FEAT_BITS-1:0] features,
    output logic                          clf_rst,
    input  logic [$clog2(CLASS_CNT)-1:0]  pred_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(CLASS_CNT)-1:0]  out_class,
    output logic                          out_err,
    output logic [15:0]                   sample_cnt
);

    localparam int unsigned IW = $clog2(FEAT_CNT);
    localparam int unsigned CW = $clog2(SETTLE_CYCLES);
    localparam int unsigned PW = $clog2(CLASS_CNT);

    localparam logic [IW-1:0] IDX_LAST = IW'(FEAT_CNT - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [PW:0]   PRED_LIM = (PW + 1)'(CLASS_CNT);

    feeder_state_e   state_q;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   cnt_q;
    logic            in_ready_q;
    logic            clf_rst_q;
    logic            out_valid_q;
    logic [PW-1:0]   out_class_q;
    logic            out_err_q;
    logic [15:0]     sample_cnt_q;

    logic            accept;
    logic            res_take;
    logic            pred_bad;

    // in_ready_q is only ever high in LOAD, so it alone qualifies the accept.
    assign accept   = in_valid & in_ready_q;
    assign res_take = out_valid_q & out_ready;
    assign pred_bad = ({1'b0, pred_in} >= PRED_LIM);

    bnn_feat_shift #(
        .CNT  (FEAT_CNT),
        .BITS (FEAT_BITS)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .din      (in_feat),
        .vec      (features)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOAD;
            idx_q        <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
            clf_rst_q    <= 1'b1;
            out_valid_q  <= 1'b0;
            out_class_q  <= '0;
            out_err_q    <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        if (idx_q == IDX_LAST) begin
                            idx_q      <= '0;
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            clf_rst_q  <= 1'b0;
                            state_q    <= SETTLE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q       <= '0;
                        clf_rst_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        out_class_q <= pred_in;
                        out_err_q   <= pred_bad;
                        state_q     <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (res_take) begin
                        out_valid_q  <= 1'b0;
                        in_ready_q   <= 1'b1;
                        sample_cnt_q <= sample_cnt_q + 16'd1;
                        state_q      <= LOAD;
                    end
                end
                default: begin
                    idx_q       <= '0;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    clf_rst_q   <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= LOAD;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign clf_rst    = clf_rst_q;
    assign out_valid  = out_valid_q;
    assign out_class  = out_class_q;
    assign out_err    = out_err_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: doc/bnn_feature_feeder.md
# bnn_feature_feeder

Producer-side front end for the sequential ROM-weight BNN classifiers (`romesx_seq` and its per-dataset wrappers). It accepts one quantized feature per handshake from a narrow stream and assembles the packed `features` vector, holding it stable while the classifier runs. It controls the classifier's reset window, then captures `prediction` and returns it on a valid/ready result port. It sits between the sample source (test-vector ROM or host interface) and one classifier instance.

## Interface
- `FEAT_CNT`, 19, features per sample.
- `FEAT_BITS`, 4, bits per feature.
- `CLASS_CNT`, 3, number of classes; the prediction width is `$clog2(CLASS_CNT)`.
- `SETTLE_CYCLES`, 45, classifier run length in cycles with reset deasserted. It must be ≥ `HIDDEN_CNT + CLASS_CNT` of the attached classifier.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  feature stream valid.
- `in_ready`  out  1  feature stream ready.
- `in_feat`  in  `FEAT_BITS`  one unsigned feature.
- `features`  out  `FEAT_CNT*FEAT_BITS`  packed vector to the classifier; feature 0 occupies bits `[FEAT_BITS-1:0]`.
- `clf_rst`  out  1  reset for the classifier instance.
- `pred_in`  in  `$clog2(CLASS_CNT)`  classifier `prediction`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumer ready.
- `out_class`  out  `$clog2(CLASS_CNT)`  captured prediction.
- `out_err`  out  1  captured prediction was ≥ `CLASS_CNT`.
- `sample_cnt`  out  16  number of results consumed; wraps from 0xFFFF to 0.

## Operation
- **States:**
  - `LOAD`: `in_ready`=1.
  - `SETTLE`: classifier is running.
  - `HOLD`: `out_valid`=1.
- **Reset values:** state `LOAD`, `features`=0, `clf_rst`=1, `out_valid`=0, `out_class`=0, `out_err`=0, `sample_cnt`=0, feature index 0, settle counter 0.
- **LOAD:**
  - Each handshake (`in_valid & in_ready`) shifts `features` right by `FEAT_BITS` and inserts `in_feat` at the top `FEAT_BITS` bits. After `FEAT_CNT` accepts, the first-accepted feature is therefore in the LSBs.
  - The feature index counts 0 to `FEAT_CNT-1`.
  - On the accept with index `FEAT_CNT-1`, go to `SETTLE` and clear the index.
  - `in_valid` gaps are allowed and have no other effect.
- **SETTLE:**
  - `clf_rst`=0, `in_ready`=0, and `features` is frozen.
  - The counter counts 0 to `SETTLE_CYCLES-1`.
  - In the cycle where count is `SETTLE_CYCLES-1`:
    - register `pred_in` into `out_class`;
    - set `out_err` = (`pred_in` ≥ `CLASS_CNT`);
    - go to `HOLD`.
- **HOLD:**
  - `clf_rst`=1, `in_ready`=0.
  - `out_class` and `out_err` are stable until the handshake.
  - On `out_valid & out_ready`: go to `LOAD` and increment `sample_cnt`.
- `clf_rst` is registered and equals 0 exactly during `SETTLE`. The classifier restarts from reset for every sample.
- `features` keeps the last sample's value in `HOLD` and during the next load. The vector is only guaranteed complete during `SETTLE`.
- Asserting `rst` in any state returns every register to its reset value immediately. A partially loaded sample or pending result is discarded.

## Timing
- `in_ready` is a registered state decode. It drops in the cycle after the final feature accept.
- `clf_rst` is 0 for exactly `SETTLE_CYCLES` cycles, starting the cycle after the final accept.
- `out_valid` rises `SETTLE_CYCLES+1` cycles after the final accept edge.
- `in_ready` rises the cycle after the result handshake.
- The earliest next feature accept is one cycle after the result handshake. Minimum sample period is `FEAT_CNT + SETTLE_CYCLES + 1` cycles.
- There is no combinational path from inputs to `in_ready`, `out_valid` or `clf_rst`.

## Structure
- **Shared package `bnn_pkg`:**
  - the state enum (`LOAD`, `SETTLE`, `HOLD`);
  - width helper constants: `IDX_W = $clog2(FEAT_CNT)`, `CNT_W = $clog2(SETTLE_CYCLES)`, `PRED_W = $clog2(CLASS_CNT)`.
- **Sub-module `bnn_feat_shift`:** the parameterized shift register, with inputs `shift_en` and `din` and output `vec`. It is reusable for other feeders.
- FSM, counters and output registers live in the top module.

## Test plan
All scenarios use default parameters and a classifier stub driving a constant `pred_in`.
- **Reset:** assert `rst`, then release. Required: `in_ready`=1, `clf_rst`=1, `out_valid`=0, `features`=0, `sample_cnt`=0.
- **Back-to-back load:** stream features k mod 16 for k=0..18 with `pred_in`=2.
  - `features[3:0]`=0, `features[7:4]`=1, `features[75:72]`=2.
  - `in_ready` is 0 one cycle after the 19th accept.
  - `clf_rst` is low for exactly 45 cycles.
  - `out_valid` rises 46 cycles after the last accept, with `out_class`=2 and `out_err`=0.
- **Random `in_valid` gaps (~50%):** the same 19 features produce an identical `features` vector and `out_class`.
- **Backpressure:** hold `out_ready`=0 for 10 cycles. Required:
  - `out_valid`, `out_class` and `clf_rst`=1 stay stable, and `in_ready`=0.
  - Releasing `out_ready` gives `in_ready`=1 the next cycle and `sample_cnt`=1.
- **Out-of-range prediction:** `pred_in`=3. Required: `out_class`=3, `out_err`=1.
- **Reset mid-run:** assert `rst` at cycle 20 of `SETTLE`. Required:
  - immediately `clf_rst`=1, `out_valid`=0, `in_ready`=1;
  - a fresh 19-feature load then completes normally.
